// File: rtl/uart_int_ctrl.sv
// Purpose: UART interrupt arbiter. Prioritises RLS > RDA > CTI > THRE into a 16550 IIR code and owns the character-timeout counter.
// Latency: 1 PCLK from a change in a pending condition to o_iir/o_intr (both registered on the same edge).
// Backpressure: none. All strobes are single-cycle events, and the block never stalls its sources.
//
// Ports:
//   PCLK, PRESETn        clock, asynchronous active-low reset
//   i_ier                interrupt enables (bit0 RDA/CTI, bit1 THRE, bit2 RLS, bit3 reserved)
//   i_fifo_en, i_rx_trig FIFO mode and RX trigger level (1/4/8/14)
//   i_word_length, i_parity_en, i_num_of_stop_bits   character frame, sets the timeout threshold
//   i_bit_tick           one pulse per RX bit time
//   i_rx_count, i_rx_push, i_rx_pop   RX FIFO occupancy and traffic strobes
//   i_lsr_err            sticky line-status error from the register file
//   i_tx_fifo_empty, i_thr_wr          TX holding status and THR write strobe
//   i_iir_rd             IIR read strobe
//   o_iir, o_intr        IIR[3:0] code and interrupt request
//   TXDRDYn, RXDRDYn     DMA ready outputs (active low)
//
// Optional feature: define UART_INT_DMA_EN to build the registered DMA ready outputs.
// Without it, both DMA outputs are tied high.

module uart_int_ctrl #(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 6
) (
    input  logic                          PCLK,
    input  logic                          PRESETn,
    input  logic [3:0]                    i_ier,
    input  logic                          i_fifo_en,
    input  logic [1:0]                    i_rx_trig,
    input  logic [1:0]                    i_word_length,
    input  logic                          i_parity_en,
    input  logic                          i_num_of_stop_bits,
    input  logic                          i_bit_tick,
    input  logic [$clog2(FIFO_DEPTH):0]   i_rx_count,
    input  logic                          i_rx_push,
    input  logic                          i_rx_pop,
    input  logic                          i_lsr_err,
    input  logic                          i_tx_fifo_empty,
    input  logic                          i_thr_wr,
    input  logic                          i_iir_rd,
    output logic [3:0]                    o_iir,
    output logic                          o_intr,
    output logic                          TXDRDYn,
    output logic                          RXDRDYn
);

    localparam int RXC_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [3:0] IIR_RLS  = 4'b0110;
    localparam logic [3:0] IIR_RDA  = 4'b0100;
    localparam logic [3:0] IIR_CTI  = 4'b1100;
    localparam logic [3:0] IIR_THRE = 4'b0010;
    localparam logic [3:0] IIR_NONE = 4'b0001;

    logic [RXC_W-1:0] trig;
    logic [3:0]       char_bits;
    logic [CNT_W-1:0] thr;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             cti_flag;
    logic             thre_flag;
    logic             thre_prev;
    logic             ier1_prev;
    logic             rx_empty;
    logic             rx_at_trig;
    logic             cti_clr;
    logic             cnt_clr;
    logic             thre_set;
    logic             thre_clr;
    logic             rls_pend;
    logic             rda_pend;
    logic             cti_pend;
    logic             thre_pend;
    logic [3:0]       iir_nxt;
    logic             unused_ier3;

    // IER bit 3 is reserved and has no effect.
    assign unused_ier3 = i_ier[3];

    always_comb begin
        trig = RXC_W'(1);
        case (i_rx_trig)
            2'b00:   trig = RXC_W'(1);
            2'b01:   trig = RXC_W'(4);
            2'b10:   trig = RXC_W'(8);
            default: trig = RXC_W'(14);
        endcase
    end

    // The frame is start + data + parity + stop bits. A 1.5 stop-bit setting counts as 2.
    // The timeout fires after four character times.
    assign char_bits = 4'd6 + {2'b00, i_word_length} + {3'b000, i_parity_en}
                     + (i_num_of_stop_bits ? 4'd2 : 4'd1);
    assign thr       = CNT_W'({char_bits, 2'b00});

    assign rx_empty   = (i_rx_count == '0);
    assign rx_at_trig = (i_rx_count >= trig);
    assign cti_clr    = i_rx_push | i_rx_pop | rx_empty;
    assign cnt_clr    = cti_clr | ~i_fifo_en;

    // Clearing takes precedence over a tick. The counter saturates at the threshold.
    always_comb begin
        cnt_nxt = cnt;
        if (cnt_clr) begin
            cnt_nxt = '0;
        end else if (i_bit_tick && (cnt < thr)) begin
            cnt_nxt = cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cnt      <= '0;
            cti_flag <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            if (cti_clr) begin
                cti_flag <= 1'b0;
            end else if (cnt_nxt >= thr) begin
                cti_flag <= 1'b1;
            end
        end
    end

    // THRE is raised by an empty edge, or by enabling THRE while already empty.
    // A clear in the same cycle wins.
    assign thre_set = i_tx_fifo_empty & (~thre_prev | (i_ier[1] & ~ier1_prev));
    assign thre_clr = i_thr_wr | (i_iir_rd & (o_iir == IIR_THRE));

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            thre_flag <= 1'b0;
            thre_prev <= 1'b0;
            ier1_prev <= 1'b0;
        end else begin
            thre_prev <= i_tx_fifo_empty;
            ier1_prev <= i_ier[1];
            if (thre_clr) begin
                thre_flag <= 1'b0;
            end else if (thre_set) begin
                thre_flag <= 1'b1;
            end
        end
    end

    assign rls_pend  = i_ier[2] & i_lsr_err;
    assign rda_pend  = i_ier[0] & (i_fifo_en ? rx_at_trig : ~rx_empty);
    assign cti_pend  = i_ier[0] & cti_flag;
    // Masking with the clear lets an IIR read or THR write drop the code on the very next update.
    assign thre_pend = i_ier[1] & thre_flag & ~thre_clr;

    always_comb begin
        iir_nxt = IIR_NONE;
        if (rls_pend) begin
            iir_nxt = IIR_RLS;
        end else if (rda_pend) begin
            iir_nxt = IIR_RDA;
        end else if (cti_pend) begin
            iir_nxt = IIR_CTI;
        end else if (thre_pend) begin
            iir_nxt = IIR_THRE;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            o_iir  <= IIR_NONE;
            o_intr <= 1'b0;
        end else begin
            o_iir  <= iir_nxt;
            o_intr <= ~iir_nxt[0];
        end
    end

`ifdef UART_INT_DMA_EN
    // DMA requests ignore IER. The receive side always releases on an empty FIFO.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            TXDRDYn <= 1'b1;
            RXDRDYn <= 1'b1;
        end else begin
            TXDRDYn <= ~i_tx_fifo_empty;
            RXDRDYn <= ~(~rx_empty & (i_fifo_en ? (rx_at_trig | cti_flag) : 1'b1));
        end
    end
`else
    assign TXDRDYn = 1'b1;
    assign RXDRDYn = 1'b1;
`endif

endmodule

// File: tb/tb_uart_int_ctrl.sv
module tb_uart_int_ctrl;

    logic       PCLK = 1'b0;
    logic       PRESETn;
    logic [3:0] i_ier;
    logic       i_fifo_en;
    logic [1:0] i_rx_trig;
    logic [1:0] i_word_length;
    logic       i_parity_en;
    logic       i_num_of_stop_bits;
    logic       i_bit_tick;
    logic [4:0] i_rx_count;
    logic       i_rx_push;
    logic       i_rx_pop;
    logic       i_lsr_err;
    logic       i_tx_fifo_empty;
    logic       i_thr_wr;
    logic       i_iir_rd;
    logic [3:0] o_iir;
    logic       o_intr;
    logic       TXDRDYn;
    logic       RXDRDYn;

    uart_int_ctrl #(.FIFO_DEPTH(16), .CNT_W(6)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .i_ier(i_ier), .i_fifo_en(i_fifo_en),
        .i_rx_trig(i_rx_trig), .i_word_length(i_word_length), .i_parity_en(i_parity_en),
        .i_num_of_stop_bits(i_num_of_stop_bits), .i_bit_tick(i_bit_tick),
        .i_rx_count(i_rx_count), .i_rx_push(i_rx_push), .i_rx_pop(i_rx_pop),
        .i_lsr_err(i_lsr_err), .i_tx_fifo_empty(i_tx_fifo_empty), .i_thr_wr(i_thr_wr),
        .i_iir_rd(i_iir_rd), .o_iir(o_iir), .o_intr(o_intr),
        .TXDRDYn(TXDRDYn), .RXDRDYn(RXDRDYn)
    );

    always #5 PCLK = ~PCLK;

`ifdef UART_INT_DMA_EN
    localparam bit DMA = 1'b1;
`else
    localparam bit DMA = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_model = 1'b0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: interrupt state tracked as plain flags and integers.
    int         m_cnt;
    bit         m_cti, m_thre, m_tprev, m_ier1p, m_intr, m_txd, m_rxd;
    logic [3:0] m_iir;

    function automatic int trig_of(input logic [1:0] s);
        int levels[4] = '{1, 4, 8, 14};
        return levels[s];
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_cti = 0; m_thre = 0; m_tprev = 0; m_ier1p = 0;
        m_iir = 4'b0001; m_intr = 0; m_txd = 1; m_rxd = 1;
    endtask

    task automatic model_edge();
        int thr, trig, cnt_n, cnt;
        bit rx_zero, clr_thre, cti_n, thre_n;
        bit pend[4];
        logic [3:0] codes[4] = '{4'b0110, 4'b0100, 4'b1100, 4'b0010};
        logic [3:0] iir_n;
        if (!PRESETn) begin
            model_reset();
            return;
        end
        thr   = 4 * (1 + 5 + int'(i_word_length) + int'(i_parity_en) + (i_num_of_stop_bits ? 2 : 1));
        trig  = trig_of(i_rx_trig);
        cnt   = int'(i_rx_count);
        rx_zero = (cnt == 0);
        if (i_rx_push || i_rx_pop || rx_zero || !i_fifo_en) cnt_n = 0;
        else if (i_bit_tick && m_cnt < thr)                 cnt_n = m_cnt + 1;
        else                                                cnt_n = m_cnt;
        cti_n    = (i_rx_push || i_rx_pop || rx_zero) ? 1'b0 : (m_cti || cnt_n >= thr);
        clr_thre = i_thr_wr || (i_iir_rd && m_iir == 4'b0010);
        thre_n   = clr_thre ? 1'b0
                 : (m_thre || (i_tx_fifo_empty && (!m_tprev || (i_ier[1] && !m_ier1p))));
        pend[0] = i_ier[2] && i_lsr_err;
        pend[1] = i_ier[0] && (i_fifo_en ? cnt >= trig : !rx_zero);
        pend[2] = i_ier[0] && m_cti;
        pend[3] = i_ier[1] && m_thre && !clr_thre;
        iir_n = 4'b0001;
        for (int k = 3; k >= 0; k--) if (pend[k]) iir_n = codes[k];
        if (DMA) begin
            m_txd = !i_tx_fifo_empty;
            m_rxd = !(!rx_zero && (i_fifo_en ? (cnt >= trig || m_cti) : 1'b1));
        end
        m_iir   = iir_n;
        m_intr  = (iir_n != 4'b0001);
        m_cnt   = cnt_n;
        m_cti   = cti_n;
        m_thre  = thre_n;
        m_tprev = i_tx_fifo_empty;
        m_ier1p = i_ier[1];
    endtask

    task automatic step();
        @(posedge PCLK);
        model_edge();
        #1;
        if (cmp_model) begin
            check("model_iir",  {4'b0, o_iir}, {4'b0, m_iir});
            check("model_intr", {7'b0, o_intr}, {7'b0, m_intr});
            check("model_txd",  {7'b0, TXDRDYn}, {7'b0, m_txd});
            check("model_rxd",  {7'b0, RXDRDYn}, {7'b0, m_rxd});
        end
    endtask

    task automatic check_iir(input string name, input logic [3:0] exp);
        check(name, {4'b0, o_iir}, {4'b0, exp});
        check({name, "_intr"}, {7'b0, o_intr}, {7'b0, exp != 4'b0001});
    endtask

    typedef struct {
        logic [3:0] ier;
        logic       fifo_en;
        logic [1:0] trig;
        logic [4:0] cnt;
        logic       lsr;
        logic [3:0] iir;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int rxc;
        bit quiet;
        tbl[0]  = '{4'b0000, 1'b1, 2'b00, 5'd5,  1'b1, 4'b0001};
        tbl[1]  = '{4'b0100, 1'b1, 2'b00, 5'd0,  1'b1, 4'b0110};
        tbl[2]  = '{4'b0001, 1'b1, 2'b01, 5'd3,  1'b0, 4'b0001};
        tbl[3]  = '{4'b0001, 1'b1, 2'b01, 5'd4,  1'b0, 4'b0100};
        tbl[4]  = '{4'b0001, 1'b1, 2'b11, 5'd13, 1'b0, 4'b0001};
        tbl[5]  = '{4'b0001, 1'b1, 2'b11, 5'd14, 1'b0, 4'b0100};
        tbl[6]  = '{4'b0001, 1'b1, 2'b10, 5'd8,  1'b0, 4'b0100};
        tbl[7]  = '{4'b0001, 1'b0, 2'b11, 5'd1,  1'b0, 4'b0100};
        tbl[8]  = '{4'b0001, 1'b0, 2'b11, 5'd0,  1'b0, 4'b0001};
        tbl[9]  = '{4'b0101, 1'b1, 2'b00, 5'd16, 1'b1, 4'b0110};
        tbl[10] = '{4'b0001, 1'b1, 2'b00, 5'd16, 1'b1, 4'b0100};
        tbl[11] = '{4'b1000, 1'b1, 2'b00, 5'd16, 1'b1, 4'b0001};

        PRESETn = 1'b1;
        i_ier = '0; i_fifo_en = 0; i_rx_trig = '0; i_word_length = '0; i_parity_en = 0;
        i_num_of_stop_bits = 0; i_bit_tick = 0; i_rx_count = '0; i_rx_push = 0; i_rx_pop = 0;
        i_lsr_err = 0; i_tx_fifo_empty = 0; i_thr_wr = 0; i_iir_rd = 0;
        model_reset();
        #1 PRESETn = 1'b0;
        #1;
        check_iir("reset_iir", 4'b0001);
        check("reset_txd", {7'b0, TXDRDYn}, 8'd1);
        check("reset_rxd", {7'b0, RXDRDYn}, 8'd1);
        step(); step();
        PRESETn = 1'b1;
        step();

        // Static pending combinations
        foreach (tbl[i]) begin
            i_ier = tbl[i].ier; i_fifo_en = tbl[i].fifo_en; i_rx_trig = tbl[i].trig;
            i_rx_count = tbl[i].cnt; i_lsr_err = tbl[i].lsr;
            step(); step();
            check_iir($sformatf("tbl%0d", i), tbl[i].iir);
        end

        // Character timeout, 8N1 gives a threshold of 40 bit times
        i_lsr_err = 0; i_ier = 4'b0001; i_fifo_en = 1; i_rx_trig = 2'b11;
        i_word_length = 2'b11; i_parity_en = 0; i_num_of_stop_bits = 0; i_rx_count = 5'd2;
        i_rx_push = 1; step(); i_rx_push = 0; step();
        for (int t = 0; t < 39; t++) begin
            i_bit_tick = 1; step(); i_bit_tick = 0; step();
        end
        check_iir("cti_39", 4'b0001);
        i_bit_tick = 1; step(); i_bit_tick = 0; step();
        check_iir("cti_40", 4'b1100);
        i_rx_pop = 1; step(); i_rx_pop = 0; step();
        check_iir("cti_pop", 4'b0001);

        // THRE set by edge, cleared by IIR read and by THR write
        i_rx_count = 0; i_ier = 4'b0010; i_tx_fifo_empty = 0; step(); step();
        i_tx_fifo_empty = 1; step(); step();
        check_iir("thre_set", 4'b0010);
        i_iir_rd = 1; step(); i_iir_rd = 0;
        check_iir("thre_iir_rd", 4'b0001);
        i_tx_fifo_empty = 0; step(); i_tx_fifo_empty = 1; step(); step();
        check_iir("thre_rise2", 4'b0010);
        i_thr_wr = 1; step(); i_thr_wr = 0;
        check_iir("thre_thr_wr", 4'b0001);
        i_ier = 4'b0000; step(); step();
        i_ier = 4'b0010; step(); step();
        check_iir("thre_ier_rise", 4'b0010);
        i_thr_wr = 1; step(); i_thr_wr = 0; step();

        // Priority RLS > RDA > THRE
        i_ier = 4'b0111; i_fifo_en = 1; i_rx_trig = 2'b00; i_tx_fifo_empty = 0; step();
        i_rx_count = 5'd5; i_lsr_err = 1; i_tx_fifo_empty = 1; step(); step();
        check_iir("prio_rls", 4'b0110);
        i_lsr_err = 0; step();
        check_iir("prio_rda", 4'b0100);
        i_rx_count = 0; step();
        check_iir("prio_thre", 4'b0010);
        i_thr_wr = 1; step(); i_thr_wr = 0;

        // DMA ready outputs
        i_ier = 4'b0000; i_tx_fifo_empty = 1; step();
        check("dma_txd_empty", {7'b0, TXDRDYn}, {7'b0, !DMA});
        i_fifo_en = 0; i_rx_count = 0; step();
        check("dma_rxd_zero", {7'b0, RXDRDYn}, 8'd1);
        i_rx_count = 5'd1; step();
        check("dma_rxd_one", {7'b0, RXDRDYn}, {7'b0, !DMA});
        i_tx_fifo_empty = 0; step();
        check("dma_txd_full", {7'b0, TXDRDYn}, 8'd1);

        // Randomised traffic against the model, with a mid-run reset
        cmp_model = 1'b1;
        rxc = 1;
        i_fifo_en = 1;
        for (int i = 0; i < 6000; i++) begin
            quiet = ((i / 400) % 2) == 1;
            if (i == 3000) begin
                PRESETn = 1'b0;
                #1;
                check_iir("midrst_iir", 4'b0001);
                check("midrst_txd", {7'b0, TXDRDYn}, 8'd1);
                check("midrst_rxd", {7'b0, RXDRDYn}, 8'd1);
                model_reset();
                step();
                PRESETn = 1'b1;
            end
            i_bit_tick = quiet ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 3) == 0);
            i_rx_push  = quiet ? ($urandom_range(0, 299) == 0) : ($urandom_range(0, 9) == 0);
            i_rx_pop   = quiet ? ($urandom_range(0, 299) == 0) : ($urandom_range(0, 9) == 0);
            if (i_rx_push && rxc < 16) rxc++;
            if (i_rx_pop && rxc > 0)   rxc--;
            if (!quiet && $urandom_range(0, 49) == 0) rxc = $urandom_range(0, 16);
            i_rx_count = 5'(rxc);
            if ($urandom_range(0, 31) == 0)  i_ier = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 149) == 0) i_fifo_en = ~i_fifo_en;
            if ($urandom_range(0, 199) == 0) begin
                i_rx_trig = 2'($urandom_range(0, 3));
                i_word_length = 2'($urandom_range(0, 3));
                i_parity_en = 1'($urandom_range(0, 1));
                i_num_of_stop_bits = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, quiet ? 299 : 39) == 0) i_lsr_err = ~i_lsr_err;
            if ($urandom_range(0, 29) == 0) i_tx_fifo_empty = ~i_tx_fifo_empty;
            i_thr_wr = ($urandom_range(0, 39) == 0);
            i_iir_rd = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_int_ctrl.md
Name: uart_int_ctrl

Overview:
Interrupt arbiter and scheduler for the UART. It shares the single interrupt line between four sources: receiver line status, RX data available, character timeout, and TX holding empty. It prioritises them into a 16550-style IIR code and owns the character-timeout counter. It sits beside the register file, takes status and strobes from the register file and FIFOs, and returns IIR contents and the interrupt output.

Parameters:
FIFO_DEPTH, 16, RX FIFO depth; i_rx_count is $clog2(FIFO_DEPTH)+1 bits wide.
CNT_W, 6, timeout counter width; must hold 48.

Ports:
PCLK  in  1  system clock
PRESETn  in  1  asynchronous active-low reset
i_ier  in  4  IER[3:0]: bit0 RDA/CTI enable, bit1 THRE enable, bit2 RLS enable, bit3 reserved
i_fifo_en  in  1  FCR FIFO enable
i_rx_trig  in  2  RX trigger select: 00=1, 01=4, 10=8, 11=14 characters
i_word_length  in  2  LCR word length (5+value bits)
i_parity_en  in  1  LCR parity enable
i_num_of_stop_bits  in  1  LCR stop bits (0=1, 1=2)
i_bit_tick  in  1  one-PCLK pulse per RX bit time from baud generator
i_rx_count  in  5  RX FIFO occupancy
i_rx_push  in  1  character written into RX FIFO
i_rx_pop  in  1  RBR read strobe
i_lsr_err  in  1  OR of overrun/parity/framing/break; register file clears it on LSR read
i_tx_fifo_empty  in  1  TX FIFO / THR empty
i_thr_wr  in  1  THR write strobe
i_iir_rd  in  1  IIR read strobe (APB access phase)
o_iir  out  4  IIR[3:0]
o_intr  out  1  interrupt request, active high
TXDRDYn  out  1  DMA transmit ready, active low
RXDRDYn  out  1  DMA receive ready, active low

Behaviour:
- Reset values: o_iir=4'b0001, o_intr=0, TXDRDYn=1, RXDRDYn=1. Timeout counter is 0; cti_flag, thre_flag and thre_prev are 0.
- Pending conditions:
  - RLS = i_ier[2] & i_lsr_err.
  - RDA = i_ier[0] & (i_fifo_en ? i_rx_count >= trig : i_rx_count != 0).
  - CTI = i_ier[0] & cti_flag.
  - THRE = i_ier[1] & thre_flag.
- Priority is fixed: RLS > RDA > CTI > THRE. The winner's code is registered into o_iir: RLS 0110, RDA 0100, CTI 1100, THRE 0010, none 0001.
- o_intr = registered (o_iir[0]==0). Latency is 1 PCLK from a pending change to o_iir/o_intr.
- Timeout counter:
  - char_bits = 1 + (5+i_word_length) + i_parity_en + (i_num_of_stop_bits ? 2 : 1). Range 7..12; 1.5 stop bits counts as 2.
  - Threshold = 4*char_bits, range 28..48.
  - Counter clears on i_rx_push, on i_rx_pop, or when i_rx_count==0 or i_fifo_en==0.
  - Otherwise it increments on i_bit_tick.
  - When the counter reaches the threshold it saturates and sets cti_flag.
  - cti_flag clears on i_rx_push, i_rx_pop or i_rx_count==0.
  - A clear and a tick in the same cycle: clear wins.
- THRE flag:
  - Set on a rising edge of i_tx_fifo_empty (thre_prev registered).
  - Also set when i_ier[1] goes 0→1 while i_tx_fifo_empty=1.
  - Cleared by i_thr_wr, or by i_iir_rd while o_iir==0010.
  - A set and a clear in the same cycle: clear wins.
- An IIR read returns the currently registered o_iir. Only a THRE code is cleared by the read; RLS, RDA and CTI clear only through their source conditions.
- IER changes take effect on the next o_iir update. Disabling a source does not clear its flag.
- A reset asserted mid-operation returns all state to reset values asynchronously. No pending state survives reset.

Optional Feature:
Macro UART_INT_DMA_EN.
- Defined: RXDRDYn is registered and low while (i_fifo_en ? (i_rx_count>=trig | cti_flag) : i_rx_count!=0); it returns high when i_rx_count==0. TXDRDYn is registered and low while i_tx_fifo_empty=1, high otherwise. Both ignore i_ier.
- Not defined: TXDRDYn and RXDRDYn are tied to 1 and no DMA logic is built.

Test Plan:
- Reset: assert PRESETn=0 mid-traffic → o_iir=0001, o_intr=0, counter=0, DMA outputs=1 within 0 cycles of assertion.
- RDA trigger: i_fifo_en=1, i_rx_trig=01, i_ier=0001; push to count 3 → o_iir=0001; count 4 → o_iir=0100, o_intr=1 one cycle later; pop to 3 → 0001.
- CTI: 8N1 (threshold 40), count=2, i_ier[0]=1; 39 bit ticks → no CTI; 40th → o_iir=1100 next cycle; i_rx_pop → o_iir=0001.
- THRE clear: i_ier=0010, i_tx_fifo_empty rises → o_iir=0010, o_intr=1; i_iir_rd → o_iir=0001. Repeat the rise, then i_thr_wr → cleared.
- Priority: RLS, RDA and THRE all pending → 0110. Drop i_lsr_err → 0100. Drain the FIFO → 0010.
- DMA (UART_INT_DMA_EN): i_tx_fifo_empty=1 → TXDRDYn=0. i_rx_count 0→1 with i_fifo_en=0 → RXDRDYn=0 next cycle. Without the macro, both stay 1.
